// File: rtl/sound_dac_mixer.sv
// -----------------------------------------------------------------------------
// sound_dac_mixer
//
// Multi-channel DAC output stage for the sound subsystem. It latches the
// offset-binary DAC writes from each sound board and scales every channel by
// its volume. Once per mix frame it sums the channels with saturation. The
// mixed sample is also converted into a first-order sigma-delta bitstream for
// a single-pin audio output.
//
// Ports:
//   clk        in  1                  single clock, rising edge
//   rst        in  1                  synchronous, active-high reset
//   dac_en     in  CHANNELS           per-channel write strobe
//   dac_value  in  CHANNELS*WIDTH     channel i at [i*WIDTH +: WIDTH]
//   vol        in  CHANNELS*VOL_BITS  channel i at [i*VOL_BITS +: VOL_BITS]
//   mute       in  1                  force mixed output to midscale
//   mix_value  out WIDTH              mixed sample, offset-binary
//   mix_valid  out 1                  one-cycle pulse on mix_value update
//   pdm_out    out 1                  sigma-delta bitstream of mix_value
// -----------------------------------------------------------------------------
module sound_dac_mixer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int VOL_BITS = 4,
  parameter int TICK_DIV = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          dac_en,
  input  logic [CHANNELS*WIDTH-1:0]    dac_value,
  input  logic [CHANNELS*VOL_BITS-1:0] vol,
  input  logic                         mute,
  output logic [WIDTH-1:0]             mix_value,
  output logic                         mix_valid,
  output logic                         pdm_out
);

  // Frame must be long enough for ACC (CHANNELS cycles) + SAT + OUT + IDLE.
  generate
    if (TICK_DIV < CHANNELS + 3) begin : g_bad_tick_div
      $error("sound_dac_mixer: TICK_DIV must be at least CHANNELS+3");
    end
  endgenerate

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int KW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Sized so CHANNELS full-scale terms at maximum volume cannot overflow.
  localparam int ACC_W = WIDTH + VOL_BITS + $clog2(CHANNELS) + 1;
  localparam int PRD_W = WIDTH + VOL_BITS + 1;

  localparam logic [CNT_W-1:0]        TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [KW-1:0]           K_LAST    = KW'(CHANNELS - 1);
  localparam logic [WIDTH-1:0]        MIDSCALE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

  // Offset-binary <-> two's complement is a flip of the MSB in both directions.
  function automatic logic [WIDTH-1:0] flip_msb(input logic [WIDTH-1:0] v);
    return v ^ MIDSCALE;
  endfunction

  // Clamp the accumulator into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [WIDTH-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[WIDTH-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[WIDTH-1:0];
    end else begin
      r = a[WIDTH-1:0];
    end
    return r;
  endfunction

  state_t                   state_r;
  state_t                   state_n;
  logic [CNT_W-1:0]         cnt_r;
  logic                     tick_s;
  logic [KW-1:0]            k_r;
  logic [WIDTH-1:0]         hold_r [CHANNELS];
  logic [WIDTH-1:0]         snap_r [CHANNELS];
  logic [VOL_BITS-1:0]      vol_s  [CHANNELS];
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [WIDTH-1:0]  samp_s;
  logic signed [PRD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]  term_s;
  logic [WIDTH-1:0]         sd_r;
  logic [WIDTH:0]           sd_sum_s;

  assign tick_s   = (cnt_r == TICK_LAST);
  assign sd_sum_s = {1'b0, sd_r} + {1'b0, mix_value};

  // Unpack the flat volume bus into per-channel fields.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      vol_s[i] = vol[i*VOL_BITS +: VOL_BITS];
    end
  end

  // Scaled term of the channel currently visited; vol is read live here.
  always_comb begin
    samp_s = $signed(flip_msb(snap_r[k_r]));
    prod_s = samp_s * $signed({1'b0, vol_s[k_r]});
    term_s = ACC_W'(prod_s >>> (VOL_BITS - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_n = ACC;
        end else begin
          state_n = IDLE;
        end
      end
      ACC: begin
        if (k_r == K_LAST) begin
          state_n = SAT;
        end else begin
          state_n = ACC;
        end
      end
      SAT:     state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Hold/snapshot registers, frame counter, accumulator and mixed output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hold_r[i] <= MIDSCALE;
        snap_r[i] <= MIDSCALE;
      end
      cnt_r     <= '0;
      k_r       <= '0;
      acc_r     <= '0;
      mix_value <= MIDSCALE;
      mix_valid <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (dac_en[i]) begin
          hold_r[i] <= dac_value[i*WIDTH +: WIDTH];
        end
      end

      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      // Snapshot takes the pre-write hold value, so a coincident write
      // belongs to the following frame.
      if (tick_s) begin
        for (int i = 0; i < CHANNELS; i++) begin
          snap_r[i] <= hold_r[i];
        end
      end

      mix_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // Clearing while idle means ACC always starts from zero.
          acc_r <= '0;
          k_r   <= '0;
        end
        ACC: begin
          acc_r <= acc_r + term_s;
          k_r   <= k_r + KW'(1);
        end
        SAT: begin
          // Registered here so the new sample is visible during OUT.
          if (mute) begin
            mix_value <= MIDSCALE;
          end else begin
            mix_value <= flip_msb(saturate(acc_r));
          end
          mix_valid <= 1'b1;
        end
        OUT: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= '0;
          k_r   <= '0;
        end
      endcase
    end
  end

  // First-order sigma-delta: the carry out of the phase accumulator is the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_r    <= '0;
      pdm_out <= 1'b0;
    end else begin
      sd_r    <= sd_sum_s[WIDTH-1:0];
      pdm_out <= sd_sum_s[WIDTH];
    end
  end

endmodule

// File: tb/tb_sound_dac_mixer.sv
// -----------------------------------------------------------------------------
// tb_sound_dac_mixer
//
// Directed self-checking bench for sound_dac_mixer with default parameters
// (2 channels, 8-bit samples, 4-bit volume, 64-clock frame). Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sound_dac_mixer;

  logic        clk;
  logic        rst;
  logic [1:0]  dac_en;
  logic [15:0] dac_value;
  logic [7:0]  vol;
  logic        mute;
  logic [7:0]  mix_value;
  logic        mix_valid;
  logic        pdm_out;

  int n_cmp;
  int n_bad;

  sound_dac_mixer #(
    .CHANNELS(2),
    .WIDTH(8),
    .VOL_BITS(4),
    .TICK_DIV(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dac_en(dac_en),
    .dac_value(dac_value),
    .vol(vol),
    .mute(mute),
    .mix_value(mix_value),
    .mix_valid(mix_valid),
    .pdm_out(pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next mix_valid pulse and return the sample.
  task automatic next_frame(output logic [7:0] v);
    bit got;
    got = 1'b0;
    v   = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mix_valid) begin
        got = 1'b1;
        v   = mix_value;
        break;
      end
    end
    if (!got) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_ch(input int ch, input logic [7:0] v);
    @(negedge clk);
    dac_en[ch] = 1'b1;
    dac_value[ch*8 +: 8] = v;
    @(negedge clk);
    dac_en = 2'b00;
  endtask

  task automatic write2(input logic [7:0] v0, input logic [7:0] v1);
    @(negedge clk);
    dac_en    = 2'b11;
    dac_value = {v1, v0};
    @(negedge clk);
    dac_en = 2'b00;
  endtask

  // Release reset at the current negedge and check the post-reset behaviour.
  task automatic release_and_check(input string tag);
    int n;
    int m;
    rst = 1'b0;
    check({tag, "_mix_rst"}, 32'(mix_value), 32'h80);
    check({tag, "_valid_rst"}, 32'(mix_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check({tag, "_pdm_alt"}, 32'(pdm_out), 32'(i % 2 == 0));
    end
    n = 4;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (mix_valid) break;
    end
    check({tag, "_first_valid_edge"}, 32'(n), 32'd67);
    check({tag, "_first_value"}, 32'(mix_value), 32'h80);
    m = 0;
    while (m < 200) begin
      @(negedge clk);
      m++;
      if (mix_valid) break;
    end
    check({tag, "_valid_period"}, 32'(m), 32'd64);
  endtask

  initial begin
    logic [7:0] v;
    int ones;
    bit saw_valid;

    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    dac_en    = 2'b00;
    dac_value = 16'h8080;
    vol       = {4'd8, 4'd8};
    mute      = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    release_and_check("reset");

    // Unity pass-through.
    write_ch(0, 8'hFF);
    next_frame(v);
    check("unity_ff", 32'(v), 32'hFF);
    write_ch(0, 8'h00);
    next_frame(v);
    check("unity_00", 32'(v), 32'h00);

    // Gain and floor rounding.
    vol = {4'd8, 4'd4};
    write2(8'hC0, 8'h40);
    next_frame(v);
    check("gain_half", 32'(v), 32'h60);
    vol = {4'd4, 4'd4};
    write2(8'h81, 8'h7F);
    next_frame(v);
    check("floor_neg", 32'(v), 32'h7F);

    // Saturation at both rails.
    vol = {4'd15, 4'd15};
    write2(8'hFF, 8'hFF);
    next_frame(v);
    check("sat_pos", 32'(v), 32'hFF);
    write2(8'h00, 8'h00);
    next_frame(v);
    check("sat_neg", 32'(v), 32'h00);

    // Sigma-delta duty for 0xC0.
    vol = {4'd8, 4'd8};
    write2(8'hC0, 8'h80);
    next_frame(v);
    check("mix_c0", 32'(v), 32'hC0);
    next_frame(v);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    check("pdm_ones_c0", 32'(ones), 32'd192);

    // Write coincident with the tick lands in the following frame.
    next_frame(v);
    check("pre_coinc", 32'(v), 32'hC0);
    repeat (60) @(negedge clk);
    dac_en[0]      = 1'b1;
    dac_value[7:0] = 8'hA0;
    @(negedge clk);
    dac_en = 2'b00;
    next_frame(v);
    check("coinc_old", 32'(v), 32'hC0);
    next_frame(v);
    check("coinc_new", 32'(v), 32'hA0);

    // Mute forces midscale.
    mute = 1'b1;
    write_ch(0, 8'hFF);
    next_frame(v);
    check("mute", 32'(v), 32'h80);
    mute = 1'b0;
    next_frame(v);
    check("unmute", 32'(v), 32'hFF);

    // Zero sample gives a silent bitstream.
    write_ch(0, 8'h00);
    next_frame(v);
    check("mix_00", 32'(v), 32'h00);
    next_frame(v);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    check("pdm_ones_00", 32'(ones), 32'd0);

    // Reset during ACC aborts the frame.
    next_frame(v);
    write_ch(0, 8'hFF);
    repeat (59) @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mix_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    check("abort_pdm", 32'(pdm_out), 32'd0);
    release_and_check("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
